// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART receive path.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } rx_state_e;

   // One FIFO entry holds {framing_err, parity_err, data}.
   function automatic int fifo_entry_width(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible on rdata_o.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;  // NOTE: default first so no path leaves count_d unassigned (no latch).
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;  // NOTE: non-blocking so every flop samples pre-edge values.
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // NOTE: storage is not reset; the empty flag guards every read of stale contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity, 1/2 stop bits
// and a small receive FIFO carrying per-word error flags.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic                 baud_en,
   input  logic                 rd,
   input  logic                 clr_err,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 rda,
   output logic                 overrun
);

   localparam int EW = fifo_entry_width(DATA_BITS);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
   localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE/2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   localparam logic PAR_EN  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
   localparam logic PAR_SUM = (PARITY == PAR_ODD);

   logic [1:0]           sync_q;
   logic                 rxs;
   rx_state_e            state_q;
   logic [TW-1:0]        tcnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 s0_q;
   logic                 s1_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 push_q;
   logic [EW-1:0]        word_q;
   logic                 overrun_q;
   logic                 vote;
   logic                 drop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [EW-1:0]        head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], rxd};
   end

   assign rxs = sync_q[1];

   // Third sample is the live line value on the decision tick.
   assign vote = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tcnt_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         s0_q      <= 1'b1;
         s1_q      <= 1'b1;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         push_q    <= 1'b0;
         word_q    <= '0;
      end else begin
         push_q <= 1'b0;
         if (baud_en) begin
            tcnt_q <= tcnt_q + 1'b1;
            if (tcnt_q == T_S0) s0_q <= rxs;
            if (tcnt_q == T_S1) s1_q <= rxs;

            unique case (state_q)
               ST_IDLE: begin
                  tcnt_q <= '0;
                  if (!rxs) begin
                     // The detecting tick is tick 0 of the start bit.
                     state_q   <= ST_START;
                     tcnt_q    <= TW'(1);
                     bit_cnt_q <= '0;
                     perr_q    <= 1'b0;
                     ferr_q    <= 1'b0;
                  end
               end

               ST_START: begin
                  if (tcnt_q == T_DEC && vote) begin
                     state_q <= ST_IDLE;
                     tcnt_q  <= '0;
                  end else if (tcnt_q == T_LAST) begin
                     state_q <= ST_DATA;
                     tcnt_q  <= '0;
                  end
               end

               ST_DATA: begin
                  if (tcnt_q == T_DEC) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                  if (tcnt_q == T_LAST) begin
                     tcnt_q    <= '0;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == B_LAST) state_q <= PAR_EN ? ST_PARITY : ST_STOP1;
                  end
               end

               ST_PARITY: begin
                  if (tcnt_q == T_DEC) perr_q <= ((^shift_q) ^ vote) != PAR_SUM;
                  if (tcnt_q == T_LAST) begin
                     state_q <= ST_STOP1;
                     tcnt_q  <= '0;
                  end
               end

               ST_STOP1: begin
                  if (STOP_BITS == 1) begin
                     // Single stop bit: push on the decision tick so the next start edge is caught.
                     if (tcnt_q == T_DEC) begin
                        push_q  <= 1'b1;
                        word_q  <= {~vote, perr_q, shift_q};
                        state_q <= ST_IDLE;
                        tcnt_q  <= '0;
                     end
                  end else begin
                     if (tcnt_q == T_DEC) ferr_q <= ~vote;
                     if (tcnt_q == T_LAST) begin
                        state_q <= ST_STOP2;
                        tcnt_q  <= '0;
                     end
                  end
               end

               ST_STOP2: begin
                  if (tcnt_q == T_DEC) begin
                     push_q  <= 1'b1;
                     word_q  <= {ferr_q | ~vote, perr_q, shift_q};
                     state_q <= ST_IDLE;
                     tcnt_q  <= '0;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
                  tcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   // A same-cycle read makes room, so only an unread push into a full FIFO is lost.
   assign drop = push_q && fifo_full && !rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overrun_q <= 1'b0;
      else if (drop)    overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
   end

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_q),
      .wdata_i (word_q),
      .pop_i   (rd),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rda         = !fifo_empty;
   assign rx_data     = fifo_empty ? '0 : head[DATA_BITS-1:0];
   assign parity_err  = PAR_EN && !fifo_empty && head[DATA_BITS];
   assign framing_err = !fifo_empty && head[DATA_BITS+1];
   assign overrun     = overrun_q;

endmodule
